// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain -- read-side consumer stage of async_fifo_top (rclk domain).
//
// Pops the FIFO only while it is non-empty and while skid-buffer credit is
// available, absorbs the FIFO's one-cycle read latency in a small circular
// skid buffer, and presents the words downstream as a valid/ready stream.
// Full throughput needs SKID_DEPTH >= 3.
//
// Optional feature: define FIFO_RD_DRAIN_STATS_EN to enable the word/stall
// statistics counters. When undefined, word_count and stall_count are tied 0.
//
// Ports:
//   rclk         read-domain clock, all state on posedge
//   reset        asynchronous, active-high reset
//   enable       drain permission; 0 stops new pops
//   fifo_empty   FIFO empty flag
//   fifo_ren     FIFO read enable (pop)
//   fifo_rdata   FIFO data_out, valid the cycle after a sampled pop
//   out_valid    downstream word available
//   out_ready    downstream accepts
//   out_data     downstream word
//   word_count   completed output handshakes (wraps)
//   stall_count  cycles with out_valid & ~out_ready (wraps)
module fifo_rd_drain #(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_ren,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(SKID_DEPTH);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             inflight;

  logic [OCC_W-1:0] occupancy;
  logic             handshake;

  // Credit check: words already buffered plus the one in flight must leave a
  // free slot for the word this pop will return. Depends on registered state
  // only, so out_ready never reaches fifo_ren combinationally.
  assign occupancy = {1'b0, count} + {{(OCC_W-1){1'b0}}, inflight};
  assign fifo_ren  = enable & ~fifo_empty & ~reset & (occupancy < DEPTH_OCC);

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign handshake = out_valid & out_ready;

  // ---- stage boundary: pop issued -> word returned by FIFO (inflight) ----
  // ---- stage boundary: returned word -> skid buffer -> downstream ----
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= fifo_ren;
      if (inflight) begin
        mem[wr_ptr] <= fifo_rdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (handshake) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Capture and handshake in the same cycle leave the fill level as is.
      case ({inflight, handshake})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_RD_DRAIN_STATS_EN
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] word_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake) begin
        word_cnt <= word_cnt + STAT_ONE;
      end
      if (out_valid && !out_ready) begin
        stall_cnt <= stall_cnt + STAT_ONE;
      end
    end
  end

  assign word_count  = word_cnt;
  assign stall_count = stall_cnt;
`else
  assign word_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer stage of async_fifo_top; runs entirely in the rclk domain.
- Issues pops only when the FIFO is non-empty, so the FIFO is never over-read.
- Absorbs the FIFO's one-cycle read latency in a small skid buffer.
- Presents the data downstream as a valid/ready stream with full throughput and no loss under backpressure.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- SKID_DEPTH, 4, skid buffer entries; power of 2, minimum 2. Full throughput requires 3 or more.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- rclk  input  1  read-domain clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  drain permission; 0 stops new pops.
- fifo_empty  input  1  FIFO empty flag (rclk domain).
- fifo_ren  output  1  FIFO read enable.
- fifo_rdata  input  WIDTH  FIFO data_out; valid the cycle after a sampled pop.
- out_valid  output  1  downstream word available.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream word.
- word_count  output  CNT_WIDTH  completed output handshakes.
- stall_count  output  CNT_WIDTH  backpressure cycles.

Behaviour:
- State:
  - Circular buffer of SKID_DEPTH x WIDTH entries.
  - wr_ptr and rd_ptr, each log2(SKID_DEPTH) bits, wrapping naturally.
  - count, 0..SKID_DEPTH, log2(SKID_DEPTH)+1 bits.
  - inflight, 1 bit: registered copy of fifo_ren.
- fifo_ren (combinational from registered state only):
  - fifo_ren = enable & ~fifo_empty & ~reset & (count + inflight < SKID_DEPTH).
  - No combinational path from out_ready to fifo_ren.
- Capture:
  - When inflight=1, fifo_rdata is written to buf[wr_ptr] at the posedge; wr_ptr++ and count++.
  - Credit accounting guarantees the capture slot exists. A capture into a full buffer cannot occur.
- Output:
  - out_valid = (count != 0).
  - out_data = buf[rd_ptr].
  - Handshake = out_valid & out_ready; on a handshake, rd_ptr++ and count--.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Simultaneous capture and handshake: count unchanged, both pointers advance.
- Latency:
  - A pop in cycle N makes the word visible on out_data in cycle N+2.
  - Steady state with out_ready=1 and the FIFO non-empty: one word per cycle (count=1, inflight=1).
- Ordering: strict FIFO order; no duplication or drop of any popped word.
- enable deasserted mid-stream: no new pops; any inflight word is still captured.
- fifo_empty rising while inflight=1: the inflight word is still captured.
- Reset (asynchronous):
  - count, pointers, inflight, word_count and stall_count go to 0.
  - out_valid=0 and out_data=0 immediately (buffer entries cleared to 0).
  - fifo_ren is forced 0 while reset is high.
  - A word in flight when reset asserts is discarded. Upstream resets the FIFO together with this block.

Optional Feature:
- Macro: FIFO_RD_DRAIN_STATS_EN.
- Defined:
  - word_count increments on each handshake.
  - stall_count increments on each cycle with out_valid & ~out_ready.
  - Both wrap modulo 2^CNT_WIDTH.
  - Both reset to 0.
- Undefined:
  - Both ports are still present, tied to constant 0, with no counter registers.

Test Plan:
- Reset mid-stream (count=3, inflight=1): assert reset between clock edges -> out_valid=0, out_data=0, fifo_ren=0 before the next edge. After release, the first output is a fresh FIFO word; no stale data.
- Streaming: fifo_empty=0, fifo_rdata = 1,2,3,... one cycle after each pop, enable=1, out_ready=1 -> first fifo_ren in cycle 0, out_valid in cycle 2 with out_data=1. Then one word per cycle, 1..50 in order.
- Backpressure: out_ready=0 from cycle 5 -> fifo_ren deasserts once count + inflight = 4; count stays at 4; out_data holds. out_ready=1 again -> words continue in order, no gaps or duplicates.
- Empty boundary: FIFO holds 3 words, then fifo_empty=1 -> exactly 3 pops, 3 outputs, out_valid=0 afterwards; fifo_ren never high while fifo_empty=1.
- Enable pause: drop enable in the same cycle as a pop -> that word is still delivered; no further fifo_ren until enable=1.
- Stats:
  - With FIFO_RD_DRAIN_STATS_EN: 10 handshakes plus 3 cycles with out_ready=0 and out_valid=1 -> word_count=10, stall_count=3.
  - Without the macro: both stay 0.
  - CNT_WIDTH=4 with 17 handshakes -> word_count=1.
